// File: rtl/prbs_xnor_checker.sv
// Receive-side checker for an XNOR-feedback Fibonacci PRBS: self-synchronises, locks, counts bit errors.
// LOCK/ERR are registered one cycle after the deciding enabled bit; EN=0 stalls all state except CLR.
module prbs_xnor_checker #(
  parameter int N        = 7,
  parameter int TAP      = 6,
  parameter int LOCK_CNT = 16,
  parameter int UNLOCK   = 4,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RN,
  inout  wire              VDD,
  inout  wire              VSS,
  input  logic             EN,
  input  logic             D,
  input  logic             CLR,
  output logic             LOCK,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam int FILL_W = (N > 1) ? $clog2(N) : 1;
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [N-1:0]      sr, sr_nxt;
  logic [FILL_W-1:0] fill, fill_nxt;
  logic [RUN_W-1:0]  run, run_nxt;
  logic [BAD_W-1:0]  bad, bad_nxt;
  logic              err_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              pred;
  logic              match;

  wire unused_supply = VDD ^ VSS;

  assign pred  = ~(sr[N-1] ^ sr[TAP-1]);
  assign match = (D == pred);

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    fill_nxt  = fill;
    run_nxt   = run;
    bad_nxt   = bad;
    err_nxt   = 1'b0;
    cnt_nxt   = ERR_CNT;
    if (EN) begin
      case (state)
        FILL: begin
          sr_nxt = {sr[N-2:0], D};
          if (fill == FILL_LAST) begin
            state_nxt = SEARCH;
            fill_nxt  = '0;
            run_nxt   = '0;
          end else begin
            fill_nxt = fill + 1'b1;
          end
        end
        SEARCH: begin
          sr_nxt = {sr[N-2:0], D};
          // All-ones is the XNOR lock-up state: it predicts itself forever.
          if (match && !(&sr)) begin
            if (run == RUN_LAST) begin
              state_nxt = LOCKED;
              run_nxt   = '0;
              bad_nxt   = '0;
            end else begin
              run_nxt = run + 1'b1;
            end
          end else begin
            run_nxt = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a single flipped bit costs one error.
          sr_nxt = {sr[N-2:0], pred};
          if (!match) begin
            err_nxt = 1'b1;
            run_nxt = '0;
            if (ERR_CNT != CNT_MAX) cnt_nxt = ERR_CNT + 1'b1;
            if (bad == BAD_LAST) begin
              state_nxt = SEARCH;
              bad_nxt   = '0;
            end else begin
              bad_nxt = bad + 1'b1;
            end
          end else if (run == RUN_LAST) begin
            run_nxt = '0;
            bad_nxt = '0;
          end else begin
            run_nxt = run + 1'b1;
          end
        end
        default: state_nxt = FILL;
      endcase
    end
    if (CLR) cnt_nxt = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state   <= FILL;
      sr      <= '0;
      fill    <= '0;
      run     <= '0;
      bad     <= '0;
      LOCK    <= 1'b0;
      ERR     <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      fill    <= fill_nxt;
      run     <= run_nxt;
      bad     <= bad_nxt;
      LOCK    <= (state_nxt == LOCKED);
      ERR     <= err_nxt;
      ERR_CNT <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_prbs_xnor_checker.sv
// Scoreboarded bench: dut 0 uses defaults, dut 1 uses CNT_W=4 / UNLOCK=64; both share stimulus.
module tb_prbs_xnor_checker;

  logic clk = 1'b0;
  logic rn, en, d, clr;
  wire  vdd, vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  logic        lock_a, err_a;
  logic [15:0] cnt_a;
  logic        lock_b, err_b;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  prbs_xnor_checker u_a (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .EN(en), .D(d), .CLR(clr),
    .LOCK(lock_a), .ERR(err_a), .ERR_CNT(cnt_a)
  );

  prbs_xnor_checker #(.CNT_W(4), .UNLOCK(64)) u_b (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .EN(en), .D(d), .CLR(clr),
    .LOCK(lock_b), .ERR(err_b), .ERR_CNT(cnt_b)
  );

  typedef struct {
    int    edge_n;
    int    dut;
    int    what;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   edge_n = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [6:0] g;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic int actual(input int dut, input int what);
    if (dut == 0) begin
      if (what == 0) return int'(lock_a);
      if (what == 1) return int'(err_a);
      return int'(cnt_a);
    end
    if (what == 0) return int'(lock_b);
    if (what == 1) return int'(err_b);
    return int'(cnt_b);
  endfunction

  // Monitor: outputs of edge k are compared at the falling edge that follows it.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].edge_n <= edge_n) begin
      cur = sb.pop_front();
      n_chk++;
      if (cur.edge_n != edge_n) begin
        n_fail++;
        $display("FAIL %s dut%0d: expectation for edge %0d not checked until edge %0d", cur.name, cur.dut, cur.edge_n, edge_n);
      end else if (actual(cur.dut, cur.what) != cur.val) begin
        n_fail++;
        $display("FAIL %s dut%0d field%0d @edge %0d: got %0d, expected %0d", cur.name, cur.dut, cur.what, edge_n, actual(cur.dut, cur.what), cur.val);
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic dd, input logic c);
    rn = r; en = e; d = dd; clr = c;
    @(posedge clk); #1;
  endtask

  task automatic expect_val(input int dut, input int what, input int val, input string nm);
    exp_t x;
    x.edge_n = edge_n; x.dut = dut; x.what = what; x.val = val; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic expect_all(input int dut, input int lk, input int er, input int cn, input string nm);
    expect_val(dut, 0, lk, nm);
    expect_val(dut, 1, er, nm);
    expect_val(dut, 2, cn, nm);
  endtask

  task automatic next_bit(output logic b);
    b = ~(g[6] ^ g[5]);
    g = {g[5:0], b};
  endtask

  // Reset, then feed clean PRBS; lock is expected only from the 23rd bit (7 fill + 16 matches).
  task automatic reset_and_lock(input int nbits, input string nm);
    logic b;
    drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    expect_all(0, 0, 0, 0, {nm, "_rst"});
    expect_all(1, 0, 0, 0, {nm, "_rst"});
    for (int k = 1; k <= nbits; k++) begin
      next_bit(b);
      drive(1'b1, 1'b1, b, 1'b0);
      expect_val(0, 0, (k >= 23) ? 1 : 0, {nm, "_lock"});
      expect_val(1, 0, (k >= 23) ? 1 : 0, {nm, "_lock"});
      expect_val(0, 1, 0, {nm, "_err"});
    end
  endtask

  initial begin
    logic b, flip, e;
    int nb, nerr;

    // T1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      expect_all(0, 0, 0, 0, "t1_reset");
      expect_all(1, 0, 0, 0, "t1_reset");
    end

    // T2: clean stream from seed 0, 2000 bits
    g = 7'h00;
    for (int k = 1; k <= 2000; k++) begin
      next_bit(b);
      drive(1'b1, 1'b1, b, 1'b0);
      expect_val(0, 0, (k >= 23) ? 1 : 0, "t2_lock");
      expect_val(1, 0, (k >= 23) ? 1 : 0, "t2_lock");
      expect_val(0, 1, 0, "t2_err");
    end
    expect_val(0, 2, 0, "t2_cnt");

    // T3a: single flipped bit, EN held high
    for (int k = 1; k <= 600; k++) begin
      next_bit(b);
      flip = (k == 300);
      drive(1'b1, 1'b1, b ^ flip, 1'b0);
      expect_val(0, 1, int'(flip), "t3_err");
      expect_val(0, 0, 1, "t3_lock");
    end
    expect_val(0, 2, 1, "t3_cnt");

    // T3b: same with EN randomly gated
    nb = 0;
    for (int i = 0; i < 1200; i++) begin
      e = 1'($urandom_range(0, 1));
      if (e) begin
        nb++;
        next_bit(b);
        flip = (nb == 300);
        drive(1'b1, 1'b1, b ^ flip, 1'b0);
        expect_val(0, 1, int'(flip), "t3en_err");
      end else begin
        drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        expect_val(0, 1, 0, "t3en_err");
      end
      expect_val(0, 0, 1, "t3en_lock");
    end
    expect_val(0, 2, (nb >= 300) ? 2 : 1, "t3en_cnt");

    // CLR acts while EN is low; lock holds
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    expect_all(0, 1, 0, 0, "clr_no_en");

    // T4a: constant ones parks the shift register in the lock-up state
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    expect_all(0, 0, 0, 0, "t4_rst");
    for (int k = 0; k < 500; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      expect_val(0, 0, 0, "t4_ones_lock");
      expect_val(1, 0, 0, "t4_ones_lock");
      expect_val(0, 1, 0, "t4_ones_err");
    end

    // T4b: lock, then constant zeros; every predicted one is an error, 4th drops lock
    reset_and_lock(23, "t4");
    nerr = 0;
    for (int k = 0; k < 60; k++) begin
      next_bit(b);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      if (nerr < 4) begin
        if (b) nerr++;
        expect_val(0, 1, int'(b), "t4_zero_err");
        expect_val(0, 0, (nerr < 4) ? 1 : 0, "t4_zero_lock");
      end else begin
        expect_val(0, 1, 0, "t4_unlocked_err");
        expect_val(0, 0, 0, "t4_unlocked_lock");
      end
    end
    expect_val(0, 2, 4, "t4_cnt");

    // T5: 30 isolated errors; dut1 saturates at 15, dut0 keeps counting
    reset_and_lock(25, "t5");
    for (int n = 1; n <= 32; n++) begin
      for (int k = 0; k < 19; k++) begin
        next_bit(b);
        drive(1'b1, 1'b1, b, 1'b0);
      end
      next_bit(b);
      drive(1'b1, 1'b1, ~b, (n == 31) ? 1'b1 : 1'b0);
      if (n <= 30) begin
        expect_all(0, 1, 1, n, "t5_err");
        expect_all(1, 1, 1, (n > 15) ? 15 : n, "t5_sat");
      end else if (n == 31) begin
        expect_all(0, 1, 1, 0, "t5_clr_wins");
        expect_all(1, 1, 1, 0, "t5_clr_wins");
      end else begin
        expect_all(0, 1, 1, 1, "t5_after_clr");
        expect_all(1, 1, 1, 1, "t5_after_clr");
      end
    end
    for (int k = 0; k < 5; k++) begin
      next_bit(b);
      drive(1'b1, 1'b1, b, 1'b0);
    end

    // T6: one-cycle reset mid-lock, then relock
    reset_and_lock(30, "t6");
    expect_val(0, 2, 0, "t6_cnt");

    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
